cpu_sram_arbiter: RTL and testbench
===================================

Name: cpu_sram_arbiter

Overview:
- Sits directly downstream of the CPU core and upstream of a single shared single-port synchronous SRAM.
- Accepts the core's two sram-like request/response channels (instruction fetch and data load/store).
- Arbitrates between them, with data priority and an anti-starvation counter, and drives one SRAM port.
- Returns in-order, one-cycle-latency responses. Supports cancelling in-flight fetches on a pipeline flush.

Parameters:
- STARVE_MAX, 4, maximum consecutive data grants while an inst request is pending; the next grant then goes to inst. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request valid (read-only channel)
- inst_addr  in  32  fetch byte address (word aligned)
- inst_cancel  in  1  flush pulse; discard in-flight fetch
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid, one-cycle pulse
- inst_rdata  out  32  fetch data, valid with inst_data_ok
- data_req  in  1  data request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, already lane-replicated by the core
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid (loads and stores), one-cycle pulse
- data_rdata  out  32  load data, raw word, valid with data_data_ok
- mem_en  out  1  SRAM enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  32  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Grant decision is combinational, one grant per cycle, in cycle T.
  - inst_ok_T = inst_req & ~inst_cancel.
  - Grant data if data_req and not (inst_ok_T and starve_cnt == STARVE_MAX).
  - Otherwise grant inst if inst_ok_T.
  - Otherwise no grant.
- Outputs in the grant cycle:
  - Granted channel's addr_ok = 1; the other channel's addr_ok = 0.
  - mem_en = 1; mem_addr = granted address; mem_wdata = data_wdata.
  - mem_we = 0 for inst grants and data loads.
- Store byte enables (mem_we):
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - No alignment checking; the core raises ALE upstream.
- starve_cnt (4-bit register):
  - Increments on a data grant while inst_req is high.
  - Clears on an inst grant, or any cycle inst_req is low.
  - Saturates at STARVE_MAX.
- Response tracking, registered on each grant:
  - resp_valid <= grant.
  - resp_src <= (0 inst / 1 data).
  - resp_drop <= inst grant & inst_cancel.
  - The inst_cancel term is always 0 here because inst is not granted when cancel is high; keep it for uniformity.
- Cycle T+1 response:
  - If resp_valid & resp_src = data: data_data_ok = 1, data_rdata = mem_rdata.
  - If resp_valid & resp_src = inst & ~inst_cancel & ~resp_drop: inst_data_ok = 1, inst_rdata = mem_rdata.
  - An inst response whose response cycle coincides with inst_cancel is suppressed: data_ok stays 0, the slot is consumed.
- Back-to-back grants are allowed every cycle (fully pipelined); at most one response is outstanding, returned the next cycle.
- Responses are never back-pressured; the masters must accept data_ok pulses.
- rdata outputs are driven from mem_rdata unconditionally; they are meaningful only with data_ok.
- Reset:
  - resp_valid = 0, resp_src = 0, resp_drop = 0, starve_cnt = 0.
  - While reset is high, all addr_ok, data_ok, mem_en and mem_we are forced to 0.
  - A response in flight when reset asserts is discarded.
- Simultaneous inst_cancel and data_req: data is granted normally; cancel affects only the inst channel.

Test Plan:
- Inst only: inst_req = 1, addr 0x1c000000 → inst_addr_ok = 1 at T, mem_en = 1, mem_addr = 0x1c000000, mem_we = 0; inst_data_ok = 1 at T+1, inst_rdata = mem_rdata.
- Both requesting, data load at 0x100 → data granted at T, data_data_ok at T+1; inst_addr_ok = 0 at T.
- Stores with data_size = 00, addr 0x203 → mem_we = 4'b1000; half at 0x202 → 4'b1100; word → 4'b1111; data_data_ok pulses at T+1 each time.
- Starvation, STARVE_MAX = 4: inst_req and data_req held high → 4 data grants, then 1 inst grant, then the pattern repeats; starve_cnt returns to 0 after the inst grant.
- Cancel: inst granted at T, inst_cancel = 1 at T+1 → inst_data_ok = 0 at T+1 and inst_addr_ok = 0 at T+1; a data grant in T+1 still proceeds.
- Reset mid-flight: data load granted at T, reset = 1 at T+1 → data_data_ok = 0 and mem_en = 0 during reset; first grant after release responds normally.

Source files
------------

// File: rtl/cpu_sram_arbiter.sv
// Arbiter between the core's instruction-fetch and data sram-like channels and one
// single-port synchronous SRAM: data priority with an anti-starvation limit, one-cycle responses.
module cpu_sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       inst_ok_s;
  logic       grant_data_s;
  logic       grant_inst_s;
  logic       grant_any_s;
  logic [3:0] starve_cnt_r;
  logic       resp_valid_r;
  logic       resp_src_r;
  logic       resp_drop_r;

  // Byte lanes for a store; misaligned accesses are trapped upstream.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Grant decision: data wins unless inst has waited STARVE_MAX data grants.
  always_comb begin
    inst_ok_s    = 1'b0;
    grant_data_s = 1'b0;
    grant_inst_s = 1'b0;
    if (reset) begin
      inst_ok_s    = 1'b0;
      grant_data_s = 1'b0;
      grant_inst_s = 1'b0;
    end else begin
      inst_ok_s    = inst_req & ~inst_cancel;
      grant_data_s = data_req & ~(inst_ok_s & (starve_cnt_r == STARVE_LIM));
      grant_inst_s = inst_ok_s & ~grant_data_s;
    end
  end

  assign grant_any_s  = grant_data_s | grant_inst_s;
  assign inst_addr_ok = grant_inst_s;
  assign data_addr_ok = grant_data_s;
  assign mem_en       = grant_any_s;
  assign mem_addr     = grant_data_s ? data_addr : inst_addr;
  assign mem_wdata    = data_wdata;

  // Byte write enables, only for a granted store.
  always_comb begin
    mem_we = 4'b0000;
    if (grant_data_s & data_wr) begin
      mem_we = store_be(data_size, data_addr[1:0]);
    end else begin
      mem_we = 4'b0000;
    end
  end

  // Consecutive data grants while a fetch waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (~inst_req | grant_inst_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_data_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Single outstanding response slot, filled on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_src_r   <= 1'b0;
      resp_drop_r  <= 1'b0;
    end else begin
      resp_valid_r <= grant_any_s;
      resp_src_r   <= grant_data_s;
      resp_drop_r  <= grant_inst_s & inst_cancel;
    end
  end

  // A flush in the response cycle swallows the fetch reply but still consumes the slot.
  assign data_data_ok = ~reset & resp_valid_r & resp_src_r;
  assign inst_data_ok = ~reset & resp_valid_r & ~resp_src_r & ~inst_cancel & ~resp_drop_r;
  assign data_rdata   = mem_rdata;
  assign inst_rdata   = mem_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: per-cycle reference model plus directed literal checks.
module tb_cpu_sram_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_en;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  mem_we;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM stand-in: fresh, cycle-tagged read data every cycle.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= 32'hA5C3_0000 ^ 32'(cyc * 7);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: grant rule, starvation streak and the one pending reply.
  int streak = 0;
  bit pend_v = 1'b0;
  bit pend_d = 1'b0;
  always @(negedge clk) begin : model
    bit iok, gd, gi;
    logic [3:0] we;
    int a;
    if (reset) begin
      chk("m_rst_iaok", inst_addr_ok, 0);
      chk("m_rst_daok", data_addr_ok, 0);
      chk("m_rst_idok", inst_data_ok, 0);
      chk("m_rst_ddok", data_data_ok, 0);
      chk("m_rst_en", mem_en, 0);
      chk("m_rst_we", mem_we, 0);
      streak = 0;
      pend_v = 1'b0;
    end else begin
      iok = inst_req && !inst_cancel;
      gd  = data_req && !(iok && streak >= SM);
      gi  = !gd && iok;
      a   = int'(data_addr % 4);
      case (data_size)
        2'd0:    we = 4'(1 << a);
        2'd1:    we = (a >= 2) ? 4'd12 : 4'd3;
        default: we = 4'd15;
      endcase
      if (!(gd && data_wr)) we = 4'd0;
      chk("m_iaok", inst_addr_ok, gi);
      chk("m_daok", data_addr_ok, gd);
      chk("m_en", mem_en, gd || gi);
      chk("m_we", mem_we, we);
      if (gd || gi) begin
        chk("m_addr", mem_addr, gd ? data_addr : inst_addr);
        chk("m_wdata", mem_wdata, data_wdata);
      end
      chk("m_ddok", data_data_ok, pend_v && pend_d);
      chk("m_idok", inst_data_ok, pend_v && !pend_d && !inst_cancel);
      if (pend_v && pend_d) chk("m_drdata", data_rdata, mem_rdata);
      if (pend_v && !pend_d && !inst_cancel) chk("m_irdata", inst_rdata, mem_rdata);
      pend_v = gd || gi;
      pend_d = gd;
      if (!inst_req || gi) streak = 0;
      else if (gd && streak < SM) streak++;
    end
  end

  task automatic drive(input bit ir, input logic [31:0] ia, input bit ic, input bit dr,
                       input bit dw, input logic [1:0] ds, input logic [31:0] da,
                       input logic [31:0] dd);
    inst_req = ir; inst_addr = ia; inst_cancel = ic;
    data_req = dr; data_wr = dw; data_size = ds; data_addr = da; data_wdata = dd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step(); step();
    drive(1'b1, 32'h1c000000, 1'b0, 1'b1, 1'b0, 2'b10, 32'h80, 32'h0);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_daok", data_addr_ok, 1'b0);
    step();
    reset = 1'b0;

    // Fetch only
    drive(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    chk("i_aok", inst_addr_ok, 1'b1);
    chk("i_en", mem_en, 1'b1);
    chk("i_addr", mem_addr, 32'h1c000000);
    chk("i_we", mem_we, 4'b0000);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("i_dok", inst_data_ok, 1'b1);
    chk("i_rdata", inst_rdata, mem_rdata);
    step();

    // Both request; data load wins
    drive(1'b1, 32'h1c000004, 1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    chk("d_aok", data_addr_ok, 1'b1);
    chk("d_iaok", inst_addr_ok, 1'b0);
    chk("d_addr", mem_addr, 32'h100);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("d_dok", data_data_ok, 1'b1);
    step();

    // Stores: byte, half, word
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h203, 32'h77777777);
    chk("sb_we", mem_we, 4'b1000);
    chk("sb_wd", mem_wdata, 32'h77777777);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h202, 32'h12341234);
    chk("sh_we", mem_we, 4'b1100);
    chk("sb_dok", data_data_ok, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h200, 32'hdeadbeef);
    chk("sw_we", mem_we, 4'b1111);
    chk("sh_dok", data_data_ok, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("sw_dok", data_data_ok, 1'b1);
    step();

    // Starvation: D D D D I, repeated
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1c000000 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 2'b10, 32'h300 + 32'(4 * i), 32'h0);
      chk("starve_d", data_addr_ok, (i % 5) != 4);
      chk("starve_i", inst_addr_ok, (i % 5) == 4);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step();

    // Cancel in the fetch response cycle; concurrent data store proceeds
    drive(1'b1, 32'h1c000040, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    chk("c_iaok", inst_addr_ok, 1'b1);
    step();
    drive(1'b1, 32'h1c000044, 1'b1, 1'b1, 1'b1, 2'b10, 32'h400, 32'hcafef00d);
    chk("c_idok", inst_data_ok, 1'b0);
    chk("c_iaok2", inst_addr_ok, 1'b0);
    chk("c_daok", data_addr_ok, 1'b1);
    chk("c_we", mem_we, 4'b1111);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("c_ddok", data_data_ok, 1'b1);
    chk("c_idok2", inst_data_ok, 1'b0);
    step();

    // Reset while a load response is in flight
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h500, 32'h0);
    chk("r_daok", data_addr_ok, 1'b1);
    step();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h500, 32'h0);
    chk("r_ddok", data_data_ok, 1'b0);
    chk("r_en", mem_en, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h504, 32'h0);
    chk("r_daok2", data_addr_ok, 1'b1);
    chk("r_ddok2", data_data_ok, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("r_ddok3", data_data_ok, 1'b1);
    chk("r_rdata", data_rdata, mem_rdata);
    step();

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h1c000000 + 32'($urandom_range(0, 255) * 4),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            32'($urandom), 32'($urandom));
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
